cam_frame_ctrl: RTL and testbench
=================================

# cam_frame_ctrl

Capture sequencer between `cam_read` and the frame-buffer RAM write port. It decides which camera frames may be written. It arms on software request, aligns to the start of a frame using `CAM_vsync`, passes exactly one frame's worth of pixel writes (or every frame, in continuous mode), and reports completion, pixel count, overflow and timeout status. It runs entirely in the camera pixel clock domain.

## Interface
- `AW`, 15: frame-buffer address width.
- `NPIX`, 19200: pixels per frame (160x120); maximum writes passed per frame.
- `TW`, 21: timeout counter width.
- `TIMEOUT`, 1600000: pclk cycles allowed in ARM or CAPTURE before abort; must fit in `TW`.

Ports:
- `CAM_pclk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `CAM_vsync`  in  1  camera vsync; high = vertical blanking.
- `cap_req`  in  1  one-cycle start request; ignored unless IDLE.
- `cap_cont`  in  1  continuous mode; sampled when `cap_req` is accepted.
- `cap_abort`  in  1  forces IDLE; no `done`.
- `wr_en_in`  in  1  write strobe from `cam_read` (`DP_RAM_regW`).
- `wr_addr_in`  in  AW  write address from `cam_read`.
- `wr_en_out`  out  1  gated write strobe to RAM.
- `wr_addr_out`  out  AW  equal to `wr_addr_in`, combinational pass-through.
- `busy`  out  1  high in ARM, CAPTURE or DONE.
- `done`  out  1  one-cycle pulse at end of each captured frame.
- `frame_ok`  out  1  last frame had exactly NPIX writes; valid from `done` until next `done`.
- `overflow`  out  1  last frame had writes beyond NPIX (sticky per frame).
- `err_timeout`  out  1  sticky; cleared by accepted `cap_req` or `rst`.
- `pix_cnt`  out  AW  gated writes in current/last frame, saturates at NPIX.
- `frame_cnt`  out  8  count of `frame_ok` frames, wraps 255->0.

## Operation
- Edge detect: `vs_q <= CAM_vsync`. `vs_fall = ~CAM_vsync & vs_q`. `vs_rise = CAM_vsync & ~vs_q`. `vs_q` resets to 1.
- States: IDLE, ARM, CAPTURE, DONE.
- IDLE: accepting `cap_req` latches `cont <= cap_cont`, clears `err_timeout`, goes to ARM.
- ARM: on `vs_fall`, go to CAPTURE, clear `pix_cnt` and `overflow`, reset the timeout counter.
- CAPTURE: `wr_en_out = wr_en_in` while `pix_cnt < NPIX`. Each passed write increments `pix_cnt`. A write arriving when `pix_cnt == NPIX` is blocked and sets `overflow`. On `vs_rise`, go to DONE.
- DONE: lasts one cycle. Assert `done`; `frame_ok <= (pix_cnt == NPIX) & ~overflow`; if ok, increment `frame_cnt`. Next state is ARM if `cont`, else IDLE.
- `wr_en_out` = 0 in every state except CAPTURE.
- Timeout counter: counts cycles in ARM and in CAPTURE, cleared on every state entry. On reaching `TIMEOUT-1`: set `err_timeout`, go to IDLE, no `done`.
- Priority, highest first: `rst` > `cap_abort` > `vs_rise`/`vs_fall` transition > timeout.
- `cap_req` while busy: ignored. `cap_req` and `cap_abort` in the same cycle in IDLE: abort wins, stay IDLE.
- Clearing `cap_cont` after acceptance has no effect. `cap_abort` is the only way to stop continuous mode.

## Timing
- Reset values: state IDLE, `wr_en_out` 0, `busy` 0, `done` 0, `frame_ok` 0, `overflow` 0, `err_timeout` 0, `pix_cnt` 0, `frame_cnt` 0, `cont` 0.
- `wr_en_out` and `wr_addr_out` are combinational from the inputs and the registered state: zero latency, no added pipeline stage.
- `busy` rises the cycle after `cap_req` is accepted.
- First write passed: the cycle after the clock edge where `vs_fall` is seen.
- `done` is asserted the cycle after the edge where `vs_rise` is seen. `frame_ok`, `overflow`, `pix_cnt` and `frame_cnt` are updated in that same cycle.
- In continuous mode, DONE->ARM takes one cycle, so the next `vs_fall` (at least one blanking line later) is never missed.
- `rst` or `cap_abort` mid-CAPTURE: `wr_en_out` goes low the cycle after the edge. Any partial frame is left in RAM. `frame_cnt` is unchanged.

## Test plan
- Single shot, 19200 writes between `vs_fall` and `vs_rise` -> exactly 19200 `wr_en_out` pulses; `done` 1 cycle; `frame_ok` = 1; `frame_cnt` = 1; then IDLE and `busy` = 0.
- `cap_req` mid-frame (vsync low) -> no writes pass until after the next `vs_rise`, `vs_fall` pair; the partial current frame is fully blocked.
- 19210 writes in one frame -> 19200 pass, 10 blocked; `overflow` = 1, `frame_ok` = 0, `frame_cnt` unchanged, `pix_cnt` = 19200.
- Continuous mode over 3 frames, then `cap_abort` during frame 4 -> three `done` pulses, `frame_cnt` = 3, writes stop the cycle after abort, no fourth `done`.
- Vsync held high, `TIMEOUT` = 100 -> IDLE after 100 cycles in ARM, `err_timeout` = 1; next `cap_req` clears it.
- `rst` asserted during CAPTURE with `cap_req` high in the same cycle -> all outputs at reset values next cycle; the request is not accepted.

Source files
------------

// File: rtl/cam_frame_ctrl.sv
// Capture sequencer between cam_read and the frame-buffer write port.
// Arms on request, aligns to vsync, gates one frame (or every frame) of pixel writes.
module cam_frame_ctrl #(
    parameter int AW      = 15,
    parameter int NPIX    = 19200,
    parameter int TW      = 21,
    parameter int TIMEOUT = 1600000
) (
    input  logic          CAM_pclk,
    input  logic          rst,
    input  logic          CAM_vsync,
    input  logic          cap_req,
    input  logic          cap_cont,
    input  logic          cap_abort,
    input  logic          wr_en_in,
    input  logic [AW-1:0] wr_addr_in,
    output logic          wr_en_out,
    output logic [AW-1:0] wr_addr_out,
    output logic          busy,
    output logic          done,
    output logic          frame_ok,
    output logic          overflow,
    output logic          err_timeout,
    output logic [AW-1:0] pix_cnt,
    output logic [7:0]    frame_cnt
);

    typedef enum logic [1:0] {IDLE, ARM, CAPTURE, DONE} state_t;

    localparam logic [AW-1:0] NPIX_C     = AW'(NPIX);
    localparam logic [TW-1:0] TMO_LAST_C = TW'(TIMEOUT - 1);

    state_t        state, state_next;
    logic          vs_q, vs_fall, vs_rise;
    logic          cont;
    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit;
    logic          accept, tmo_fire;
    logic          pass, block;
    logic [AW-1:0] pix_next;
    logic          ovf_next;
    logic          ok_next;

    always_comb begin
        vs_fall     = ~CAM_vsync & vs_q;
        vs_rise     = CAM_vsync & ~vs_q;
        pass        = (state == CAPTURE) && wr_en_in && (pix_cnt < NPIX_C);
        block       = (state == CAPTURE) && wr_en_in && (pix_cnt >= NPIX_C);
        pix_next    = pass ? pix_cnt + AW'(1) : pix_cnt;
        ovf_next    = overflow | block;
        ok_next     = (pix_next == NPIX_C) && !ovf_next;
        tmo_hit     = ((state == ARM) || (state == CAPTURE)) && (tmo_cnt == TMO_LAST_C);
        wr_en_out   = pass;
        wr_addr_out = wr_addr_in;
        busy        = (state != IDLE);
        done        = (state == DONE);
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        tmo_fire   = 1'b0;
        case (state)
            IDLE: begin
                if (cap_req && !cap_abort) begin
                    accept     = 1'b1;
                    state_next = ARM;
                end
            end
            ARM: begin
                if (cap_abort)    state_next = IDLE;
                else if (vs_fall) state_next = CAPTURE;
                else if (tmo_hit) begin
                    state_next = IDLE;
                    tmo_fire   = 1'b1;
                end
            end
            CAPTURE: begin
                if (cap_abort)    state_next = IDLE;
                else if (vs_rise) state_next = DONE;
                else if (tmo_hit) begin
                    state_next = IDLE;
                    tmo_fire   = 1'b1;
                end
            end
            DONE: begin
                if (cap_abort) state_next = IDLE;
                else           state_next = cont ? ARM : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CAM_pclk) begin
        if (rst) begin
            state       <= IDLE;
            vs_q        <= 1'b1;
            cont        <= 1'b0;
            tmo_cnt     <= '0;
            pix_cnt     <= '0;
            overflow    <= 1'b0;
            frame_ok    <= 1'b0;
            frame_cnt   <= '0;
            err_timeout <= 1'b0;
        end else begin
            state <= state_next;
            vs_q  <= CAM_vsync;

            if (accept) begin
                cont        <= cap_cont;
                err_timeout <= 1'b0;
            end
            if (tmo_fire)
                err_timeout <= 1'b1;

            if ((state_next != state) || !((state_next == ARM) || (state_next == CAPTURE)))
                tmo_cnt <= '0;
            else
                tmo_cnt <= tmo_cnt + TW'(1);

            if ((state == ARM) && (state_next == CAPTURE)) begin
                pix_cnt  <= '0;
                overflow <= 1'b0;
            end else if (state == CAPTURE) begin
                pix_cnt  <= pix_next;
                overflow <= ovf_next;
            end

            // Frame result is latched on the vs_rise edge (including that cycle's write)
            // so it is already visible while done is high.
            if ((state == CAPTURE) && (state_next == DONE)) begin
                frame_ok <= ok_next;
                if (ok_next)
                    frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_cam_frame_ctrl.sv
// Directed self-checking bench for cam_frame_ctrl (NPIX=20, TIMEOUT=100).
module tb_cam_frame_ctrl;

    localparam int AW = 15;

    logic          CAM_pclk;
    logic          rst, CAM_vsync, cap_req, cap_cont, cap_abort, wr_en_in;
    logic [AW-1:0] wr_addr_in;
    logic          wr_en_out, busy, done, frame_ok, overflow, err_timeout;
    logic [AW-1:0] wr_addr_out, pix_cnt;
    logic [7:0]    frame_cnt;

    int checks = 0;
    int errors = 0;
    int npass  = 0;
    int ndone  = 0;

    cam_frame_ctrl #(.AW(AW), .NPIX(20), .TW(21), .TIMEOUT(100)) dut (
        .CAM_pclk(CAM_pclk), .rst(rst), .CAM_vsync(CAM_vsync),
        .cap_req(cap_req), .cap_cont(cap_cont), .cap_abort(cap_abort),
        .wr_en_in(wr_en_in), .wr_addr_in(wr_addr_in),
        .wr_en_out(wr_en_out), .wr_addr_out(wr_addr_out), .busy(busy),
        .done(done), .frame_ok(frame_ok), .overflow(overflow),
        .err_timeout(err_timeout), .pix_cnt(pix_cnt), .frame_cnt(frame_cnt)
    );

    initial CAM_pclk = 1'b0;
    always #5 CAM_pclk = ~CAM_pclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Inputs are set just after a falling edge; sample what the next rising edge sees,
    // then return just after the following falling edge.
    task automatic tick();
        #1;
        if (wr_en_out) npass++;
        if (done) ndone++;
        @(negedge CAM_pclk);
        #1;
    endtask

    task automatic frame(input int n);
        CAM_vsync = 1'b0; wr_en_in = 1'b0;
        tick();
        for (int i = 0; i < n; i++) begin
            wr_en_in   = 1'b1;
            wr_addr_in = AW'(i);
            tick();
        end
        wr_en_in  = 1'b0;
        CAM_vsync = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; CAM_vsync = 1'b1; cap_req = 1'b0; cap_cont = 1'b0;
        cap_abort = 1'b0; wr_en_in = 1'b1; wr_addr_in = 15'h1234;
        @(negedge CAM_pclk); #1;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wr_en", wr_en_out, 0);
        chk("rst_frame_ok", frame_ok, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_err_tmo", err_timeout, 0);
        chk("rst_pix_cnt", pix_cnt, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("addr_pass", wr_addr_out, 32'h1234);
        rst = 1'b0; wr_en_in = 1'b0;
        tick();

        // Single shot, exactly NPIX writes
        cap_req = 1'b1; tick(); cap_req = 1'b0;
        chk("ss_busy_arm", busy, 1);
        wr_en_in = 1'b1; #1;
        chk("ss_arm_blocked", wr_en_out, 0);
        wr_en_in = 1'b0;
        npass = 0;
        frame(20);
        chk("ss_done", done, 1);
        chk("ss_frame_ok", frame_ok, 1);
        chk("ss_frame_cnt", frame_cnt, 1);
        chk("ss_pix_cnt", pix_cnt, 20);
        chk("ss_overflow", overflow, 0);
        chk("ss_npass", npass, 20);
        tick();
        chk("ss_done_1cyc", done, 0);
        chk("ss_idle", busy, 0);

        // Request mid-frame: partial frame blocked, next short frame captured
        CAM_vsync = 1'b0; tick(); tick();
        cap_req = 1'b1; tick(); cap_req = 1'b0;
        npass = 0; wr_en_in = 1'b1;
        repeat (5) tick();
        wr_en_in = 1'b0;
        chk("mid_blocked", npass, 0);
        CAM_vsync = 1'b1; tick(); tick();
        chk("mid_still_arm", busy, 1);
        frame(10);
        chk("mid_done", done, 1);
        chk("mid_frame_ok", frame_ok, 0);
        chk("mid_pix_cnt", pix_cnt, 10);
        chk("mid_frame_cnt", frame_cnt, 1);
        chk("mid_npass", npass, 10);
        tick();

        // Overflow: 23 writes, 20 pass
        cap_req = 1'b1; tick(); cap_req = 1'b0;
        npass = 0;
        frame(23);
        chk("ovf_done", done, 1);
        chk("ovf_npass", npass, 20);
        chk("ovf_flag", overflow, 1);
        chk("ovf_frame_ok", frame_ok, 0);
        chk("ovf_frame_cnt", frame_cnt, 1);
        chk("ovf_pix_cnt", pix_cnt, 20);
        tick();

        // Continuous mode: 3 frames then abort in frame 4
        rst = 1'b1; tick(); rst = 1'b0;
        chk("cont_rst_fcnt", frame_cnt, 0);
        cap_req = 1'b1; cap_cont = 1'b1; tick(); cap_req = 1'b0; cap_cont = 1'b0;
        ndone = 0;
        repeat (3) begin
            frame(20);
            tick();
        end
        chk("cont_ndone", ndone, 3);
        chk("cont_frame_cnt", frame_cnt, 3);
        chk("cont_rearmed", busy, 1);
        npass = 0;
        CAM_vsync = 1'b0; tick();
        wr_en_in = 1'b1;
        repeat (5) tick();
        cap_abort = 1'b1; tick(); cap_abort = 1'b0;
        #1;
        chk("abort_wr_stop", wr_en_out, 0);
        chk("abort_idle", busy, 0);
        chk("abort_npass", npass, 6);
        wr_en_in = 1'b0; CAM_vsync = 1'b1;
        tick(); tick();
        chk("abort_no_done", ndone, 3);
        chk("abort_fcnt", frame_cnt, 3);

        // Timeout with vsync held high
        cap_req = 1'b1; tick(); cap_req = 1'b0;
        repeat (99) tick();
        chk("tmo_last_arm", busy, 1);
        chk("tmo_not_yet", err_timeout, 0);
        tick();
        chk("tmo_idle", busy, 0);
        chk("tmo_err", err_timeout, 1);
        cap_req = 1'b1; cap_abort = 1'b1; tick(); cap_req = 1'b0; cap_abort = 1'b0;
        chk("req_abort_idle", busy, 0);
        chk("req_abort_err", err_timeout, 1);
        cap_req = 1'b1; tick(); cap_req = 1'b0;
        chk("tmo_clear", err_timeout, 0);
        chk("tmo_rearm", busy, 1);
        cap_abort = 1'b1; tick(); cap_abort = 1'b0;

        // Reset mid-capture with simultaneous request
        cap_req = 1'b1; tick(); cap_req = 1'b0;
        CAM_vsync = 1'b0; tick();
        wr_en_in = 1'b1;
        repeat (3) tick();
        chk("rc_pix_cnt", pix_cnt, 3);
        rst = 1'b1; cap_req = 1'b1; tick(); rst = 1'b0; cap_req = 1'b0;
        #1;
        chk("rc_wr_en", wr_en_out, 0);
        chk("rc_busy", busy, 0);
        chk("rc_frame_ok", frame_ok, 0);
        chk("rc_pix_cnt0", pix_cnt, 0);
        chk("rc_frame_cnt", frame_cnt, 0);
        tick();
        chk("rc_not_accepted", busy, 0);
        wr_en_in = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
